power_switch_emu: RTL and testbench

- Behavioural and synthesizable emulator of the power-switch cells for the power-gated domains in the HEEPsilon testbench.
- Consumes each domain's `*_powergate_switch_n` request from heepsilon_top (CPU, peripheral, memory banks, external domains).
- Returns a `*_powergate_switch_ack_n` after a programmable ramp latency, so the power manager's handshake is exercised realistically.
- Replaces fixed delay lines with a per-domain FSM that has separate on/off latencies, abort handling and a busy indication.

---
 rtl/power_switch_emu.sv | 86 ++++++++
 tb/tb_power_switch_emu.sv | 135 +++++++++++++
 2 files changed

// File: rtl/power_switch_emu.sv
// power_switch_emu: per-domain power-switch emulator with separate on/off ramp latencies and abort.
// Define POWER_SWITCH_EMU_STATS_EN to add saturating per-domain completed power-off counters.
module power_switch_emu #(
    parameter int NUM_DOMAINS = 1,
    parameter int ON_LATENCY  = 15,
    parameter int OFF_LATENCY = 15,
    parameter int CNT_W       = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_DOMAINS-1:0]   switch_n_i,
    output logic [NUM_DOMAINS-1:0]   switch_ack_n_o,
`ifdef POWER_SWITCH_EMU_STATS_EN
    output logic [16*NUM_DOMAINS-1:0] off_count_o,
`endif
    output logic                     busy_o
);
    typedef enum logic [1:0] {S_ON, S_RAMP_OFF, S_OFF, S_RAMP_ON} state_e;

    logic [NUM_DOMAINS-1:0] ramp;

    if (ON_LATENCY < 1 || ON_LATENCY > 2**CNT_W - 1 ||
        OFF_LATENCY < 1 || OFF_LATENCY > 2**CNT_W - 1) begin : g_bad_latency
        $error("power_switch_emu: ON_LATENCY/OFF_LATENCY must be in 1..2**CNT_W-1");
    end

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_ch
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             ack_q;
`ifdef POWER_SWITCH_EMU_STATS_EN
        logic [15:0]      off_q;
`endif
        // Ramp states leave ack_q untouched so it holds the last stable value; abort wins over completion.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= S_ON;
                cnt_q   <= '0;
                ack_q   <= 1'b0;
`ifdef POWER_SWITCH_EMU_STATS_EN
                off_q   <= '0;
`endif
            end else begin
                case (state_q)
                    S_ON: if (switch_n_i[g]) begin
                        state_q <= S_RAMP_OFF;
                        cnt_q   <= CNT_W'(OFF_LATENCY - 1);
                    end
                    S_RAMP_OFF: if (!switch_n_i[g]) begin
                        state_q <= S_ON;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= S_OFF;
                        ack_q   <= 1'b1;
`ifdef POWER_SWITCH_EMU_STATS_EN
                        off_q   <= (off_q == 16'hFFFF) ? off_q : off_q + 16'd1;
`endif
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                    end
                    S_OFF: if (!switch_n_i[g]) begin
                        state_q <= S_RAMP_ON;
                        cnt_q   <= CNT_W'(ON_LATENCY - 1);
                    end
                    default: if (switch_n_i[g]) begin
                        state_q <= S_OFF;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= S_ON;
                        ack_q   <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                    end
                endcase
            end
        end

        assign ramp[g]           = (state_q == S_RAMP_OFF) || (state_q == S_RAMP_ON);
        assign switch_ack_n_o[g] = ack_q;
`ifdef POWER_SWITCH_EMU_STATS_EN
        assign off_count_o[16*g +: 16] = off_q;
`endif
    end

    assign busy_o = |ramp;
endmodule

// File: tb/tb_power_switch_emu.sv
// tb_power_switch_emu: scoreboard bench for power_switch_emu (4 domains, ON=3, OFF=15).
module tb_power_switch_emu;
    localparam int N = 4;

    typedef struct {
        int         c;
        logic [3:0] ack;
        logic       busy;
        string      tag;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sw = '0;
    logic [N-1:0] ack;
    logic         busy;
`ifdef POWER_SWITCH_EMU_STATS_EN
    logic [16*N-1:0] offc;
`endif
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    power_switch_emu #(.NUM_DOMAINS(N), .ON_LATENCY(3), .OFF_LATENCY(15), .CNT_W(8)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .switch_n_i(sw),
        .switch_ack_n_o(ack),
`ifdef POWER_SWITCH_EMU_STATS_EN
        .off_count_o(offc),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].c <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            assert (e.c == cyc && {ack, busy} === {e.ack, e.busy}) else begin
                n_err++;
                $error("FAIL %s @%0d: ack=%b busy=%b, expected ack=%b busy=%b (due %0d)",
                       e.tag, cyc, ack, busy, e.ack, e.busy, e.c);
            end
        end
    end

    task automatic push(input int c, input logic [3:0] a, input logic b, input string tag);
        exp_t e;
        e.c = c; e.ack = a; e.busy = b; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic check_now(input logic [3:0] a, input logic b, input string tag);
        n_cmp++;
        assert ({ack, busy} === {a, b}) else begin
            n_err++;
            $error("FAIL %s: ack=%b busy=%b, expected ack=%b busy=%b", tag, ack, busy, a, b);
        end
    endtask

    // Call right after changing sw at a negedge; the change is sampled on the next edge t.
    task automatic expect_ramp(input int L, input logic [3:0] a0, input logic [3:0] a1, input string tag);
        int t = cyc + 1;
        for (int k = 0; k <= L; k++) push(t + k, (k < L) ? a0 : a1, k < L, tag);
        repeat (L + 1) @(negedge clk);
    endtask

    task automatic expect_abort(input int after, input logic [3:0] a, input logic [3:0] back, input string tag);
        int t = cyc + 1;
        for (int k = 0; k <= after + 2; k++) push(t + k, a, k < after, tag);
        repeat (after) @(negedge clk);
        sw = back;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1 check_now(4'b0000, 1'b0, "reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_now(4'b0000, 1'b0, "reset_state");
        rst_n = 1'b1;
        for (int i = 1; i <= 50; i++) push(cyc + i, 4'b0000, 1'b0, "idle_after_reset");
        repeat (50) @(negedge clk);

        sw = 4'b0001; expect_ramp(15, 4'b0000, 4'b0001, "off_d0_L15");
        sw = 4'b0000; expect_ramp(3, 4'b0001, 4'b0000, "on_d0_L3");
        sw = 4'b0001; expect_abort(8, 4'b0000, 4'b0000, "abort_off_mid");
        sw = 4'b0001; expect_abort(15, 4'b0000, 4'b0000, "abort_off_last_edge");
        sw = 4'b0001; expect_ramp(15, 4'b0000, 4'b0001, "off_d0_again");
        sw = 4'b0000; expect_abort(3, 4'b0001, 4'b0001, "abort_on_last_edge");
        sw = 4'b0000; expect_ramp(3, 4'b0001, 4'b0000, "on_d0_again");
        sw = 4'b1111; expect_ramp(15, 4'b0000, 4'b1111, "off_all");
        sw = 4'b0110; expect_ramp(3, 4'b1111, 4'b0110, "on_d0_d3");
        sw = 4'b0000; expect_ramp(3, 4'b0110, 4'b0000, "on_d1_d2");

        sw = 4'b0001;
        for (int k = 1; k <= 3; k++) push(cyc + k, 4'b0000, 1'b1, "ramp_before_reset");
        repeat (3) @(negedge clk);
        pulse_reset();
        expect_ramp(15, 4'b0000, 4'b0001, "off_after_reset");
        sw = 4'b0000; expect_ramp(3, 4'b0001, 4'b0000, "on_after_reset");

        pulse_reset();
        for (int r = 0; r < 3; r++) begin
            sw = 4'b0100; expect_ramp(15, 4'b0000, 4'b0100, "stats_off_d2");
            sw = 4'b0000; expect_ramp(3, 4'b0100, 4'b0000, "stats_on_d2");
        end
        sw = 4'b0100; expect_abort(6, 4'b0000, 4'b0000, "stats_abort_d2");
`ifdef POWER_SWITCH_EMU_STATS_EN
        n_cmp++;
        assert (offc === {16'd0, 16'd3, 16'd0, 16'd0}) else begin
            n_err++;
            $error("FAIL off_count: got %h, expected %h", offc, {16'd0, 16'd3, 16'd0, 16'd0});
        end
`endif
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
        n_cmp++;
        assert (q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
